// File: rtl/kulisch_acc_seq.sv
// Sequencer for one Kulisch dot-product job: owns the redundant accumulator,
// counts product beats, then resolves sum+carry one chunk per cycle.
module kulisch_acc_seq #(
  parameter int NUM    = 4,
  parameter int AWIDTH = 92,
  parameter int LWIDTH = 16,
  parameter int CHUNK  = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LWIDTH-1:0] i_len,
  input  logic              i_abort,
  output logic              o_busy,
  input  logic              i_prod_valid,
  output logic              o_prod_ready,
  output logic [AWIDTH-1:0] o_acc_sum,
  output logic [AWIDTH-1:0] o_acc_carry,
  input  logic [AWIDTH-1:0] i_dp_sum,
  input  logic [AWIDTH-1:0] i_dp_carry,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [AWIDTH-1:0] o_res
);

  localparam int R  = AWIDTH / CHUNK;
  localparam int KW = (R > 1) ? $clog2(R) : 1;

  // Reject configurations the chunked resolver cannot handle.
  if ((AWIDTH % CHUNK) != 0 || NUM < 1) begin : g_bad_cfg
    $error("kulisch_acc_seq: AWIDTH must be a multiple of CHUNK and NUM >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [LWIDTH-1:0] cnt;
  logic [AWIDTH-1:0] acc_sum, acc_carry, res;
  logic [KW-1:0]     k;
  logic              cin;
  logic              accept;
  logic              last_beat;
  logic              last_chunk;
  logic [CHUNK:0]    chunk_sum;

  assign accept     = i_prod_valid && (state == ACCUM);
  assign last_beat  = (cnt == LWIDTH'(1));
  assign last_chunk = (k == KW'(R - 1));

  // One chunk of the carry-propagate add, with the carry-out in the top bit.
  always_comb begin
    chunk_sum = '0;
    chunk_sum = {1'b0, acc_sum[k*CHUNK +: CHUNK]}
              + {1'b0, acc_carry[k*CHUNK +: CHUNK]}
              + (CHUNK+1)'(cin);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort wins over any beat accept or result handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_start && !i_abort)
          state_nxt = (i_len != '0) ? ACCUM : RESOLVE;
      end
      ACCUM: begin
        if (i_abort)                  state_nxt = IDLE;
        else if (accept && last_beat) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (i_abort)         state_nxt = IDLE;
        else if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        if (i_abort || i_res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter, accumulator, chunk index and resolved result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc_sum   <= '0;
      acc_carry <= '0;
      res       <= '0;
      k         <= '0;
      cin       <= 1'b0;
    end else if (i_abort) begin
      if (state != IDLE) begin
        cnt       <= '0;
        acc_sum   <= '0;
        acc_carry <= '0;
        k         <= '0;
        cin       <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            acc_sum   <= '0;
            acc_carry <= '0;
            cnt       <= i_len;
            k         <= '0;
            cin       <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_sum   <= i_dp_sum;
            acc_carry <= i_dp_carry;
            cnt       <= cnt - LWIDTH'(1);
            if (last_beat) begin
              k   <= '0;
              cin <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          res[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          cin                   <= chunk_sum[CHUNK];
          k                     <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_prod_ready = (state == ACCUM);
  assign o_res_valid  = (state == DONE);
  assign o_acc_sum    = acc_sum;
  assign o_acc_carry  = acc_carry;
  assign o_res        = res;

endmodule
